// File: rtl/rst_seq_pkg.sv
// Shared types and defaults for the reset/power-up sequencer.
// The lock timeout is only built when RST_SEQ_LOCK_TMO_EN is defined.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    HOLD,
    PRE,
    PWRDN,
    LOCK,
    CORE,
    RUN
  } rst_seq_state_t;

  localparam int DEF_NREQ      = 3;
  localparam int DEF_HOLD_CYC  = 1300;
  localparam int DEF_PRE_CYC   = 300;
  localparam int DEF_PWRDN_CYC = 200;
  localparam int DEF_APP_DLY   = 16;
  localparam int DEF_LOCK_TMO  = 10000;
  localparam int DEF_CW        = 20;

  // Smallest counter width able to hold the largest terminal count (max - 1).
  function automatic int rst_seq_cw_min(input int hold_cyc, input int pre_cyc,
                                        input int pwrdn_cyc, input int app_dly,
                                        input int lock_tmo);
    int m;
    m = hold_cyc;
    if (pre_cyc > m) m = pre_cyc;
    if (pwrdn_cyc > m) m = pwrdn_cyc;
    if (app_dly > m) m = app_dly;
    if (lock_tmo > m) m = lock_tmo;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/rst_req_capture.sv
// One requester: rising-edge detect plus a pending bit that is set on an
// edge and cleared when the sequencer serves it (an edge always wins).
module rst_req_capture (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic serve,
  output logic edge_seen,
  output logic pending
);

  logic req_q;

  assign edge_seen = req & ~req_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= 1'b0;
      pending <= 1'b0;
    end else begin
      req_q <= req;
      if (edge_seen) begin
        pending <= 1'b1;
      end else if (serve) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset and transceiver power-up sequencer: HOLD -> PRE -> PWRDN -> LOCK -> CORE -> RUN.
// Define RST_SEQ_LOCK_TMO_EN to build the lock-wait timeout and sticky lock_fail flag.
//
// Handshake: req[i] is a level; only its 0->1 transition counts as a request. Each
// request is answered by exactly one single-cycle ack[i] pulse on the cycle RUN is entered.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int PRE_CYC   = DEF_PRE_CYC,
  parameter int PWRDN_CYC = DEF_PWRDN_CYC,
  parameter int APP_DLY   = DEF_APP_DLY,
  parameter int LOCK_TMO  = DEF_LOCK_TMO,
  parameter int CW        = DEF_CW
) (
  input  logic            clk,
  input  logic            sys_rst,
  input  logic [NREQ-1:0] req,
  input  logic            gxb_locked,
  output logic [NREQ-1:0] ack,
  output logic            gxb_pwrdn,
  output logic            core_rst_n,
  output logic            app_rst_n,
  output logic            busy,
  output logic [NREQ-1:0] cause,
  output logic            lock_fail,
  output rst_seq_state_t  dbg_state
);

  localparam int CW_MIN = rst_seq_cw_min(HOLD_CYC, PRE_CYC, PWRDN_CYC, APP_DLY, LOCK_TMO);

  if (CW < CW_MIN) begin : g_cw_check
    $error("rst_seq_ctrl: CW is too small for the cycle parameters");
  end

  rst_seq_state_t  state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [NREQ-1:0] edge_seen, pending;
  logic            restart, serve, counting;
`ifdef RST_SEQ_LOCK_TMO_EN
  logic            tmo_hit;
`endif

  for (genvar i = 0; i < NREQ; i++) begin : g_req
    rst_req_capture u_cap (
      .clk      (clk),
      .rst      (sys_rst),
      .req      (req[i]),
      .serve    (serve),
      .edge_seen(edge_seen[i]),
      .pending  (pending[i])
    );
  end

  always_comb begin
    state_n = state;
`ifdef RST_SEQ_LOCK_TMO_EN
    tmo_hit = 1'b0;
`endif
    case (state)
      HOLD:  if (cnt == CW'(HOLD_CYC - 1))  state_n = PRE;
      PRE:   if (cnt == CW'(PRE_CYC - 1))   state_n = PWRDN;
      PWRDN: if (cnt == CW'(PWRDN_CYC - 1)) state_n = LOCK;
      LOCK: begin
        if (gxb_locked) begin
          state_n = CORE;
`ifdef RST_SEQ_LOCK_TMO_EN
        end else if (cnt == CW'(LOCK_TMO - 1)) begin
          state_n = HOLD;
          tmo_hit = 1'b1;
`endif
        end
      end
      CORE:    if (cnt == CW'(APP_DLY - 1)) state_n = RUN;
      RUN:     state_n = RUN;
      default: state_n = HOLD;
    endcase

    // A fresh request edge overrides whatever phase we are in, HOLD included.
    restart = |edge_seen;
    if (restart) state_n = HOLD;

    serve = (state_n == RUN) && (state != RUN);

`ifdef RST_SEQ_LOCK_TMO_EN
    counting = (state != RUN);
`else
    counting = (state != RUN) && (state != LOCK);
`endif
    cnt_n = (restart || (state_n != state) || !counting) ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state      <= HOLD;
      cnt        <= '0;
      ack        <= '0;
      gxb_pwrdn  <= 1'b0;
      core_rst_n <= 1'b0;
      app_rst_n  <= 1'b0;
      busy       <= 1'b1;
      cause      <= '0;
`ifdef RST_SEQ_LOCK_TMO_EN
      lock_fail  <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      ack        <= serve ? pending : '0;
      if (serve) cause <= pending;
      gxb_pwrdn  <= (state_n == PWRDN);
      core_rst_n <= (state_n == CORE) || (state_n == RUN);
      app_rst_n  <= (state_n == RUN);
      busy       <= (state_n != RUN);
`ifdef RST_SEQ_LOCK_TMO_EN
      if (tmo_hit) lock_fail <= 1'b1;
`endif
    end
  end

`ifndef RST_SEQ_LOCK_TMO_EN
  assign lock_fail = 1'b0;
`endif

  assign dbg_state = state;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: a per-cycle reference model built from "cycles since
// sequence start", directed scenarios with literal expectations, then random traffic.
module tb_rst_seq_ctrl;

  localparam int NREQ = 3;
  localparam int H    = 8;
  localparam int P    = 4;
  localparam int W    = 3;
  localparam int A    = 2;
  localparam int TMO  = 20;
  localparam int CW   = 20;
  localparam int L    = H + P + W;
`ifdef RST_SEQ_LOCK_TMO_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            sys_rst;
  logic            gxb_locked;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] ack;
  logic [NREQ-1:0] cause;
  logic            gxb_pwrdn, core_rst_n, app_rst_n, busy, lock_fail;
  rst_seq_pkg::rst_seq_state_t dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  rst_seq_ctrl #(
    .NREQ(NREQ), .HOLD_CYC(H), .PRE_CYC(P), .PWRDN_CYC(W),
    .APP_DLY(A), .LOCK_TMO(TMO), .CW(CW)
  ) dut (
    .clk       (clk),
    .sys_rst   (sys_rst),
    .req       (req),
    .gxb_locked(gxb_locked),
    .ack       (ack),
    .gxb_pwrdn (gxb_pwrdn),
    .core_rst_n(core_rst_n),
    .app_rst_n (app_rst_n),
    .busy      (busy),
    .cause     (cause),
    .lock_fail (lock_fail),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h (state=%0d, t=%0d)", name, got, exp, dbg_state, $time);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  // t  : cycles since the current sequence started (HOLD entry)
  // lk : value of t at which core release happens, -1 while not yet locked
  int              t = 0;
  int              lk = -1;
  logic [NREQ-1:0] pend_m = '0, ackv_m = '0, cause_m = '0, prev_m = '0;
  logic            lf_m = 1'b0;

  function automatic logic [10:0] model_out();
    logic pw, core, app;
    logic [NREQ-1:0] a;
    pw   = (t >= H + P) && (t < L);
    core = (lk >= 0) && (t >= lk);
    app  = (lk >= 0) && (t >= lk + A);
    a    = ((lk >= 0) && (t == lk + A)) ? ackv_m : '0;
    return {a, pw, core, app, ~app, cause_m, lf_m};
  endfunction

  task automatic model_step();
    logic [NREQ-1:0] edges;
    logic in_lock, tmo;
    if (sys_rst) begin
      t = 0; lk = -1; pend_m = '0; ackv_m = '0; cause_m = '0; prev_m = '0; lf_m = 1'b0;
    end else begin
      edges   = req & ~prev_m;
      prev_m  = req;
      in_lock = (lk < 0) && (t >= L);
      tmo     = TMO_EN && in_lock && !gxb_locked && (t - L == TMO - 1);
      if (tmo) lf_m = 1'b1;
      if (edges != '0) begin
        pend_m = pend_m | edges;
        t = 0;
        lk = -1;
      end else if (tmo) begin
        t = 0;
      end else begin
        if (in_lock && gxb_locked) lk = t + 1;
        if ((lk >= 0) && (t + 1 == lk + A)) begin
          ackv_m  = pend_m;
          cause_m = pend_m;
          pend_m  = '0;
        end
        t++;
      end
    end
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    @(posedge clk);
    forever begin
      model_step();
      @(negedge clk);
      check("cycle_model", {ack, gxb_pwrdn, core_rst_n, app_rst_n, busy, cause, lock_fail},
            model_out());
      @(posedge clk);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic run_until_app(input int budget, output int cycles, output int n_acks,
                               output logic [NREQ-1:0] last);
    cycles = 0;
    n_acks = 0;
    last   = '0;
    while (1) begin
      if (ack != '0) begin
        n_acks++;
        last = ack;
      end
      if (app_rst_n || cycles >= budget) break;
      tick();
      cycles++;
    end
    if (!app_rst_n) begin
      n_checks++;
      $display("FAIL app_wait_timeout: app_rst_n still %0b after %0d cycles", app_rst_n, budget);
    end
  endtask

  task automatic pulse_sys_rst();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int first_pw, last_pw, core_at, app_at, cyc, na;
    logic [NREQ-1:0] la, ack18, cause18;
    logic busy17, busy18;

    sys_rst = 1'b1; req = '0; gxb_locked = 1'b1;
    busy17 = 1'b0; busy18 = 1'b1; ack18 = '1; cause18 = '1;
    repeat (3) tick();
    check("reset_values", {ack, gxb_pwrdn, core_rst_n, app_rst_n, busy, cause, lock_fail},
          11'b000_0_0_0_1_000_0);

    // Power-on: this negedge is cycle 0.
    sys_rst = 1'b0;
    first_pw = -1; last_pw = -1; core_at = -1; app_at = -1;
    for (int n = 0; n <= 20; n++) begin
      if (gxb_pwrdn) begin
        if (first_pw < 0) first_pw = n;
        last_pw = n;
      end
      if (core_rst_n && core_at < 0) core_at = n;
      if (app_rst_n && app_at < 0) app_at = n;
      if (n == 17) busy17 = busy;
      if (n == 18) begin
        busy18 = busy; ack18 = ack; cause18 = cause;
      end
      tick();
    end
    check("pon_pwrdn_first", first_pw, 12);
    check("pon_pwrdn_last", last_pw, 14);
    check("pon_core_rise", core_at, 16);
    check("pon_app_rise", app_at, 18);
    check("pon_ack", ack18, 3'b000);
    check("pon_cause", cause18, 3'b000);
    check("pon_busy_17", busy17, 1'b1);
    check("pon_busy_18", busy18, 1'b0);

    // req[1] pulse in RUN.
    repeat (3) tick();
    req = 3'b010;
    tick();
    req = '0;
    check("req1_resets_low", {gxb_pwrdn, core_rst_n, app_rst_n}, 3'b000);
    run_until_app(60, cyc, na, la);
    check("req1_app_rise", cyc + 1, 19);
    check("req1_ack", ack, 3'b010);
    check("req1_cause", cause, 3'b010);

    // Edge on the RUN entry cycle is not acked now; it restarts next cycle.
    req = 3'b100;
    tick();
    req = '0;
    check("run_entry_edge_restart", {ack, core_rst_n, app_rst_n}, 5'b000_0_0);
    run_until_app(60, cyc, na, la);
    check("run_entry_edge_ack", la, 3'b100);
    check("run_entry_edge_cause", cause, 3'b100);

    // req[0] and req[2] together during PRE (cycle 9).
    pulse_sys_rst();
    repeat (9) tick();
    req = 3'b101;
    tick();
    req = '0;
    run_until_app(60, cyc, na, la);
    check("pre_pair_app_rise", cyc, 18);
    check("pre_pair_ack", la, 3'b101);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ack != '0) na++;
    end
    check("pre_pair_single_ack", na, 1);

    // req[0] held high for 100 cycles.
    na = 0; la = '0;
    req = 3'b001;
    for (int i = 0; i < 120; i++) begin
      if (i == 100) req = '0;
      if (ack != '0) begin
        na++;
        la = ack;
      end
      tick();
    end
    check("held_req_one_ack", na, 1);
    check("held_req_ack_val", la, 3'b001);
    check("held_req_in_run", app_rst_n, 1'b1);

    // sys_rst during CORE.
    req = 3'b010;
    tick();
    req = '0;
    repeat (16) tick();
    check("core_before_rst", {core_rst_n, app_rst_n}, 2'b10);
    sys_rst = 1'b1;
    tick();
    check("sysrst_in_core", {ack, gxb_pwrdn, core_rst_n, app_rst_n, busy, cause, lock_fail},
          11'b000_0_0_0_1_000_0);
    sys_rst = 1'b0;
    run_until_app(60, cyc, na, la);
    check("sysrst_app_rise", cyc, 18);
    check("sysrst_clears_pending", {na[3:0], ack, cause}, 10'd0);

    // Lock held low for 50 cycles past PWRDN.
    pulse_sys_rst();
    gxb_locked = 1'b0;
    repeat (65) tick();
    check("lock_wait_core_low", core_rst_n, 1'b0);
`ifdef RST_SEQ_LOCK_TMO_EN
    check("lock_fail_set", lock_fail, 1'b1);
`else
    check("lock_fail_tied", lock_fail, 1'b0);
`endif
    gxb_locked = 1'b1;
    tick();
    check("lock_release", core_rst_n, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      tick();
      for (int b = 0; b < NREQ; b++)
        if ($urandom_range(0, 59) == 0) req[b] = ~req[b];
      if ($urandom_range(0, 79) == 0) gxb_locked = ~gxb_locked;
      sys_rst = ($urandom_range(0, 399) == 0);
    end
    sys_rst = 1'b0;
    req = '0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
